// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds beam position from incoming hsync/vsync and tracks
// phase lock against nominal 640x480@60 timing, counting phase/timeout errors.
module vga_sync_decoder #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] px,
  output logic [8:0] py,
  output logic       visible,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] err_count
);
  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_MAX        = H_TOTAL - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_MAX        = V_TOTAL - 1;
  localparam int TIMEOUT      = 2 * H_TOTAL;
  localparam int WW           = $clog2(TIMEOUT + 1);
  localparam int FW           = $clog2(LOCK_FRAMES + 2);

  typedef enum logic [1:0] {SEARCH, HALIGN, ACQUIRE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [9:0]    hpos_q, hpos_d, vpos_q, vpos_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [7:0]    err_q, err_d;
  logic          hs_q, vs_q;
  logic          hedge, vedge, herr, verr, terr, err;

  always_comb begin
    hedge   = hsync && !hs_q;
    vedge   = vsync && !vs_q;
    // the sync edge arrives one cycle after the transmitter's sync start position
    herr    = hedge && hpos_q != 10'(H_SYNC_START + 1);
    verr    = vedge && vpos_q != 10'(V_SYNC_START);
    terr    = !hedge && wd_q == WW'(TIMEOUT - 1);
    err     = herr || verr || terr;
    hpos_d  = hedge ? 10'(H_SYNC_START + 2) : (hpos_q == 10'(H_MAX) ? '0 : hpos_q + 10'd1);
    vpos_d  = vedge ? 10'(V_SYNC_START) :
              (hpos_q != 10'(H_MAX) ? vpos_q : (vpos_q == 10'(V_MAX) ? '0 : vpos_q + 10'd1));
    wd_d    = hedge ? '0 : (wd_q == WW'(TIMEOUT) ? wd_q : wd_q + WW'(1));
    err_d   = (err && state_q != SEARCH && err_q != 8'hff) ? err_q + 8'd1 : err_q;
    state_d = state_q;
    fc_d    = fc_q;
    case (state_q)
      SEARCH: state_d = hedge ? HALIGN : SEARCH;
      HALIGN: begin
        fc_d    = '0;
        state_d = err ? SEARCH : (vedge ? ACQUIRE : HALIGN);
      end
      ACQUIRE: begin
        fc_d    = (vedge && !err) ? fc_q + FW'(1) : fc_q;
        state_d = err ? SEARCH : ((vedge && fc_q + FW'(1) == FW'(LOCK_FRAMES)) ? LOCKED : ACQUIRE);
      end
      default: state_d = err ? SEARCH : LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      hpos_q  <= '0;
      vpos_q  <= '0;
      wd_q    <= '0;
      fc_q    <= '0;
      err_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      wd_q    <= wd_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
      hs_q    <= hsync;
      vs_q    <= vsync;
    end
  end

  assign px          = hpos_q;
  assign py          = vpos_q[8:0];
  assign locked      = state_q == LOCKED;
  assign visible     = hpos_q < 10'(H_DISPLAY) && vpos_q < 10'(V_DISPLAY) && locked;
  assign frame_start = hpos_q == '0 && vpos_q == '0 && locked;
  assign err_count   = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed vectors, generator-driven scenarios and randomized
// disturbances, all checked against an arithmetic reference model.
module tb_vga_sync_decoder;
  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 6, VF = 1, VS = 2, VB = 2;
  localparam int LF = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int HSS = HD + HF;
  localparam int VSS = VD + VF;
  localparam int TO = 2 * HT;
  localparam int FT = HT * VT;

  logic clk = 1'b0, rst = 1'b1, hsync = 1'b0, vsync = 1'b0;
  logic [9:0] px;
  logic [8:0] py;
  logic visible, locked, frame_start;
  logic [7:0] err_count;

  int n_cmp = 0, n_bad = 0;
  int n = 0, nv = 0, e0 = 0, fs_cnt = 0, vis_cnt = 0;
  logic ve_last = 1'b0;
  int m_hp = 0, m_vp = 0, m_wd = 0, m_st = -1, m_ec = 0;
  logic m_hs = 1'b0, m_vs = 1'b0;

  typedef struct {
    logic r, h, v;
    int   px, py;
    logic lk;
    int   ec;
  } vec_t;
  vec_t tbl[23];

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .px(px), .py(py), .visible(visible), .locked(locked),
    .frame_start(frame_start), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic gh(input int m);
    return m >= 0 && m % HT >= HSS && m % HT < HSS + HS;
  endfunction

  function automatic logic gv(input int m);
    return m >= 0 && (m / HT) % VT >= VSS && (m / HT) % VT < VSS + VS;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic h, input logic v);
    logic he, ve, e;
    int hp0;
    if (r) begin
      m_hp = 0; m_vp = 0; m_wd = 0; m_st = -1; m_ec = 0; m_hs = 1'b0; m_vs = 1'b0;
    end else begin
      he = h && !m_hs;
      ve = v && !m_vs;
      e = (he && m_hp != HSS + 1) || (ve && m_vp != VSS) || (!he && m_wd == TO - 1);
      if (e && m_st >= 0 && m_ec < 255) m_ec++;
      if (m_st < 0) m_st = he ? 0 : -1;
      else if (e) m_st = -1;
      else if (ve) m_st = (m_st > LF) ? LF + 1 : m_st + 1;
      hp0 = m_hp;
      m_hp = he ? HSS + 2 : (m_hp + 1) % HT;
      m_vp = ve ? VSS : (hp0 == HT - 1 ? (m_vp + 1) % VT : m_vp);
      m_wd = he ? 0 : (m_wd < TO ? m_wd + 1 : TO);
      m_hs = h;
      m_vs = v;
    end
  endtask

  task automatic cyc(input logic r, input logic h, input logic v);
    logic lk;
    rst = r; hsync = h; vsync = v;
    @(posedge clk);
    model(r, h, v);
    @(negedge clk);
    lk = m_st == LF + 1;
    chk("px", px, m_hp);
    chk("py", py, m_vp % 512);
    chk("locked", locked, lk);
    chk("visible", visible, m_hp < HD && m_vp < VD && lk);
    chk("frame_start", frame_start, m_hp == 0 && m_vp == 0 && lk);
    chk("err_count", err_count, m_ec);
  endtask

  task automatic gen(input int dly, input logic vf, input logic hk);
    ve_last = gv(n - 1) && !gv(n - 2);
    if (ve_last) nv++;
    cyc(1'b0, gh(n - 1 - dly) && !hk, gv(n - 1) || vf);
    n++;
  endtask

  task automatic restart();
    cyc(1'b1, 1'b0, 1'b0);
    n = 0;
    nv = 0;
  endtask

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 1'b0,  0, 0, 1'b0, 0}, '{1'b0, 1'b0, 1'b0,  1, 0, 1'b0, 0},
      '{1'b0, 1'b1, 1'b0, 20, 0, 1'b0, 0}, '{1'b0, 1'b1, 1'b0, 21, 0, 1'b0, 0},
      '{1'b0, 1'b0, 1'b0, 22, 0, 1'b0, 0}, '{1'b0, 1'b1, 1'b0, 20, 0, 1'b0, 1},
      '{1'b0, 1'b0, 1'b1, 21, 7, 1'b0, 1}, '{1'b0, 1'b1, 1'b1, 20, 7, 1'b0, 1},
      '{1'b0, 1'b0, 1'b0, 21, 7, 1'b0, 1}, '{1'b0, 1'b0, 1'b1, 22, 7, 1'b0, 1},
      '{1'b0, 1'b0, 1'b0, 23, 7, 1'b0, 1}, '{1'b0, 1'b0, 1'b1, 24, 7, 1'b0, 1},
      '{1'b0, 1'b0, 1'b0,  0, 8, 1'b0, 1}, '{1'b0, 1'b0, 1'b1,  1, 7, 1'b0, 2},
      '{1'b0, 1'b1, 1'b1, 20, 7, 1'b0, 2}, '{1'b0, 1'b1, 1'b0, 21, 7, 1'b0, 2},
      '{1'b0, 1'b0, 1'b1, 22, 7, 1'b0, 2}, '{1'b0, 1'b0, 1'b0, 23, 7, 1'b0, 2},
      '{1'b0, 1'b0, 1'b1, 24, 7, 1'b0, 2}, '{1'b0, 1'b0, 1'b0,  0, 8, 1'b0, 2},
      '{1'b0, 1'b1, 1'b1, 20, 7, 1'b0, 3}, '{1'b0, 1'b0, 1'b0, 21, 7, 1'b0, 3},
      '{1'b1, 1'b0, 1'b0,  0, 0, 1'b0, 0}
    };
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].r, tbl[i].h, tbl[i].v);
      chk("tbl_px", px, tbl[i].px);
      chk("tbl_py", py, tbl[i].py);
      chk("tbl_locked", locked, tbl[i].lk);
      chk("tbl_err", err_count, tbl[i].ec);
    end

    // clean stream: lock after the third vsync edge, then track the generator exactly
    restart();
    for (int i = 0; i < 5 * FT && !locked; i++) begin
      gen(0, 1'b0, 1'b0);
      if (locked) begin
        chk("lock_vedges", nv, 3);
        chk("lock_after_edge", ve_last, 1);
      end
    end
    chk("locked_in_budget", locked, 1);
    for (int i = 0; i < 3 * FT; i++) begin
      gen(0, 1'b0, 1'b0);
      chk("px_gen", px, n % HT);
      chk("py_gen", py, (n / HT) % VT);
      fs_cnt += int'(frame_start);
      vis_cnt += int'(visible);
      if (px == HD) chk("vis_right_edge", visible, 0);
      if (py == VD) chk("vis_bottom_edge", visible, 0);
      if (px == HD - 1 && py == VD - 1) chk("vis_last_pixel", visible, 1);
    end
    chk("frame_starts", fs_cnt, 3);
    chk("visible_cycles", vis_cnt, 3 * HD * VD);
    chk("clean_err", err_count, 0);

    // one hsync delayed by three cycles on line 0
    for (int i = 0; i < FT + HT && !(n % HT == HSS - 2 && (n / HT) % VT == 0); i++) gen(0, 1'b0, 1'b0);
    e0 = err_count;
    for (int i = 0; i < HT; i++) begin
      gen(3, 1'b0, 1'b0);
      if ((n - 1) % HT == HSS + 4) begin
        chk("jump_px", px, HSS + 2);
        chk("jump_locked", locked, 0);
        chk("jump_err", err_count, e0 + 1);
      end
    end
    nv = 0;
    for (int i = 0; i < 5 * FT && !locked; i++) gen(0, 1'b0, 1'b0);
    chk("relock_vedges", nv, 3);
    chk("relocked", locked, 1);

    // hsync absent while locked: one timeout error, none further in SEARCH
    e0 = err_count;
    for (int i = 0; i < TO + 5; i++) gen(0, 1'b0, 1'b1);
    chk("to_locked", locked, 0);
    chk("to_err", err_count, e0 + 1);
    for (int i = 0; i < 2 * TO; i++) gen(0, 1'b0, 1'b1);
    chk("to_search_err", err_count, e0 + 1);

    // stray vsync edge during ACQUIRE
    restart();
    for (int i = 0; i < 2 * FT && !(nv == 1 && (n / HT) % VT == 3 && n % HT == 10); i++) gen(0, 1'b0, 1'b0);
    e0 = err_count;
    gen(0, 1'b1, 1'b0);
    chk("inj_py", py, VSS);
    chk("inj_err", err_count, e0 + 1);
    gen(0, 1'b0, 1'b0);

    // alternating hsync pulses: every second edge is a phase error in HALIGN
    for (int i = 0; i < 1300; i++) cyc(1'b0, (i % 2) == 0, 1'b0);
    chk("sat_err", err_count, 255);

    for (int i = 0; i < 7; i++) gen(0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("rst_px", px, 0);
    chk("rst_py", py, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);

    restart();
    for (int i = 0; i < 8000; i++) begin
      automatic int k = $urandom_range(0, 299);
      if (k == 0) cyc(1'b1, 1'b0, 1'b0);
      else gen(k == 1 ? $urandom_range(1, 3) : 0, k == 2, k == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
